// File: rtl/mips_mc_ctrl_if.sv
// Signal bundle between the multi-cycle MIPS controller and its datapath/memory.
// mem_req/mem_ready handshake: the controller holds mem_req with stable selects until it samples mem_ready high, and ignores mem_ready at any other time.
interface mips_mc_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_source;
  logic [3:0]  state;
  logic        fault;
  logic        retire;
  logic [31:0] instr_count;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, alu_src_a,
           reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, state, fault, retire, instr_count
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, alu_src_a,
           reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, state, fault, retire, instr_count
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with bounded memory waits, a sticky fault state
// and a retired-instruction counter.
module mips_mc_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JAL    = 4'd10, S_JR     = 4'd11,
    S_ADDIEX = 4'd12, S_ADDIWB = 4'd13, S_FAULT  = 4'd15
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  wait_q;
  logic [31:0] count_q;
  logic        retire_c;
  logic        wait_last;

  // The access times out on the edge that would make the wait count reach TIMEOUT.
  assign wait_last = (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      wait_q <= '0;
      if (retire_c) count_q <= count_q + 32'd1;
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready)  state_q <= S_DECODE;
          else if (wait_last) state_q <= S_FAULT;
          else                wait_q  <= wait_q + 8'd1;
        end
        S_DECODE: begin
          case (bus.op)
            6'h23, 6'h2B: state_q <= S_MEMADR;
            6'h00:        state_q <= (bus.funct == 6'h08) ? S_JR : S_EXEC;
            6'h04:        state_q <= S_BRANCH;
            6'h02:        state_q <= S_JUMP;
            6'h03:        state_q <= S_JAL;
            6'h08:        state_q <= S_ADDIEX;
            default:      state_q <= S_FAULT;
          endcase
        end
        S_MEMADR: state_q <= (bus.op == 6'h23) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (bus.mem_ready)  state_q <= S_MEMWB;
          else if (wait_last) state_q <= S_FAULT;
          else                wait_q  <= wait_q + 8'd1;
        end
        S_MEMWR: begin
          if (bus.mem_ready)  state_q <= S_FETCH;
          else if (wait_last) state_q <= S_FAULT;
          else                wait_q  <= wait_q + 8'd1;
        end
        S_EXEC:   state_q <= S_ALUWB;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ADDIWB: state_q <= S_FETCH;
        default:  state_q <= S_FAULT;
      endcase
    end
  end

  // Outputs decode from the state register, gated so everything reads 0 while in reset.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_source  = 2'b00;
    bus.fault      = 1'b0;
    retire_c       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: bus.alu_src_b = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          bus.mem_req  = 1'b1;
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          retire_c      = bus.mem_ready;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 2'b01;
          retire_c       = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'b01;
          bus.mem_to_reg = (bus.funct == 6'h00) ? 2'b11 : 2'b00;
          retire_c       = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b01;
          bus.pc_source = 2'b01;
          bus.pc_write  = bus.zero;
          retire_c      = 1'b1;
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
          retire_c      = 1'b1;
        end
        S_JAL: begin
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b10;
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'b10;
          bus.mem_to_reg = 2'b10;
          retire_c       = 1'b1;
        end
        S_JR: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b11;
          retire_c      = 1'b1;
        end
        S_ADDIWB: begin
          bus.reg_write = 1'b1;
          retire_c      = 1'b1;
        end
        S_FAULT: bus.fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.retire      = retire_c;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;
endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum mem_ready wait cycles per memory access, range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port op, input, 6: instruction opcode, from the instruction register.
REQ-005 SHALL have port funct, input, 6: R-type function field.
REQ-006 SHALL have port zero, input, 1: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1: memory access completes this cycle.
REQ-008 SHALL have outputs mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, alu_src_a, each 1 bit: datapath strobes and selects.
REQ-009 SHALL have outputs reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source, each 2 bits: mux selects and ALU class.
REQ-010 SHALL have outputs state, 4 bits; fault, 1 bit; retire, 1 bit; instr_count, 32 bits.

Function
REQ-011 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, JAL=10, JR=11, ADDIEX=12, ADDIWB=13, FAULT=15; state output SHALL equal the current encoding.
REQ-012 Outputs not listed for a state SHALL be 0.
REQ-013 FETCH: mem_req=1, mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready (Mealy); on mem_ready go to DECODE, else stay.
REQ-014 DECODE: alu_src_b=11, alu_op=00. Next state by op: 0x23/0x2B->MEMADR; 0x00 with funct 0x08->JR; other 0x00->EXEC; 0x04->BRANCH; 0x02->JUMP; 0x03->JAL; 0x08->ADDIEX; any other op->FAULT.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEMRD if op=0x23, else MEMWR.
REQ-016 MEMRD: mem_req=1, mem_read=1, i_or_d=1; on mem_ready go to MEMWB.
REQ-017 MEMWR: mem_req=1, mem_write=1, i_or_d=1; on mem_ready retire and go to FETCH.
REQ-018 MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01; retire; go to FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; go to ALUWB. ALUWB: reg_write=1, reg_dst=01, mem_to_reg=00 (11 when funct=0x00, shift path); retire; go to FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_write=zero; retire; go to FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10; retire; go to FETCH.
REQ-022 JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10 (r31), mem_to_reg=10 (PC+4); retire; go to FETCH.
REQ-023 JR: pc_write=1, pc_source=11; retire; go to FETCH.
REQ-024 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDIWB. ADDIWB: reg_write=1, reg_dst=00, mem_to_reg=00; retire; go to FETCH.
REQ-025 retire SHALL pulse 1 cycle on the final cycle of each instruction (REQ-017..024); instr_count SHALL increment on that edge, wrapping 0xFFFFFFFF->0.
REQ-026 A wait counter SHALL clear on entering FETCH/MEMRD/MEMWR and count cycles with mem_ready=0; reaching TIMEOUT SHALL transition to FAULT on the next edge with no strobe issued.
REQ-027 mem_ready in the same cycle the counter reaches TIMEOUT SHALL complete the access normally (ready wins).
REQ-028 FAULT: fault=1, all strobes 0; FAULT SHALL be sticky until reset; instr_count SHALL hold.
REQ-029 mem_ready SHALL be ignored in states that do not assert mem_req.

Reset
REQ-030 rst_n low SHALL immediately force state=FETCH, wait counter=0, instr_count=0, fault=0, and all outputs 0 regardless of clk.
REQ-031 From the first cycle after rst_n deasserts, FETCH outputs per REQ-013 SHALL apply; reset mid-instruction or in FAULT SHALL abandon it without any strobe.

Verification
REQ-032 lw (op 0x23), mem_ready=1 each access -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; instr_count=1.
REQ-033 beq (0x04), zero=1 -> pc_write=1 with pc_source=01 in BRANCH; zero=0 -> pc_write=0; retire=1 both cases.
REQ-034 TIMEOUT=3, mem_ready held 0 in FETCH -> FAULT after 3 wait cycles, fault=1, ir_write never asserted; persists until rst_n low.
REQ-035 op 0x3F in DECODE -> FAULT next cycle; instr_count unchanged.
REQ-036 jal (0x03) -> reg_dst=10, mem_to_reg=10, pc_write=1 in JAL; jr (0x00/0x08) -> pc_source=11.
REQ-037 rst_n pulsed low mid-MEMRD -> state=0 and all outputs 0 asynchronously; instr_count=0.
